// File: rtl/dma_fifo_pkg.sv
// rtl/dma_fifo_pkg.sv - shared constants and helpers for the DMA FIFO family
package dma_fifo_pkg;

    localparam int DMA_FIFO_DW    = 32;
    localparam int DMA_FIFO_DEPTH = 32;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dma_fifo_mem.sv
// rtl/dma_fifo_mem.sv - register-array dual-port storage, sync write / async read
module dma_fifo_mem
    import dma_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DMA_FIFO_DW,
    parameter int FIFO_DEPTH = DMA_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          i_wr_en,
    input  logic [$clog2(FIFO_DEPTH)-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(FIFO_DEPTH)-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0]         o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/dma_sync_fifo.sv
// rtl/dma_sync_fifo.sv - parametrised single-clock DMA FIFO with thresholds, flush and sticky errors
// Define DMA_FIFO_FWFT_EN for first-word-fall-through read; default is registered read.
module dma_sync_fifo
    import dma_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DMA_FIFO_DW,
    parameter int FIFO_DEPTH = DMA_FIFO_DEPTH,
    parameter int AFULL_TH   = FIFO_DEPTH - 2,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                err_clr,
    input  logic                                wr_en,
    input  logic [DATA_WIDTH-1:0]               wdata,
    input  logic                                rd_en,
    output logic [DATA_WIDTH-1:0]               rdata,
    output logic                                rvalid,
    output logic                                full,
    output logic                                empty,
    output logic                                almost_full,
    output logic                                almost_empty,
    output logic [fifo_cnt_w(FIFO_DEPTH)-1:0]   count,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = fifo_cnt_w(FIFO_DEPTH);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("dma_sync_fifo: FIFO_DEPTH must be a power of two >= 2");
        end
        if (AEMPTY_TH >= AFULL_TH) begin : g_bad_th
            $error("dma_sync_fifo: AEMPTY_TH must be below AFULL_TH");
        end
    endgenerate

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_ovf_evt;
    logic                  w_udf_evt;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    // Flush wins over both requests, so neither is accepted nor flagged as an error.
    assign w_rd_acc  = rd_en && !w_empty && !flush;
    assign w_wr_acc  = wr_en && (!w_full || w_rd_acc) && !flush;
    assign w_ovf_evt = wr_en && !flush && !w_wr_acc;
    assign w_udf_evt = rd_en && !flush && !w_rd_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // A fresh error in the clear cycle survives the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (err_clr) begin
            r_overflow  <= w_ovf_evt;
            r_underflow <= w_udf_evt;
        end else begin
            r_overflow  <= r_overflow | w_ovf_evt;
            r_underflow <= r_underflow | w_udf_evt;
        end
    end

    dma_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wdata),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rdata)
    );

`ifdef DMA_FIFO_FWFT_EN
    // The array has no reset, so the head is masked while empty.
    assign rdata  = w_empty ? '0 : w_mem_rdata;
    assign rvalid = !w_empty;
`else
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_acc;
            if (w_rd_acc) r_rdata <= w_mem_rdata;
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CW'(AFULL_TH));
    assign almost_empty = (r_count <= CW'(AEMPTY_TH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
